// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter and its read-tag pipeline.
package vram_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic {
    SRC_VID = 1'b0,
    SRC_CPU = 1'b1
  } arb_src_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_DONE,
    RD_WAIT1,
    RD_WAIT2,
    RD_DONE
  } cpu_state_t;

  typedef struct packed {
    logic     valid;
    arb_src_t src;
  } rd_tag_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Two-stage {valid, src} tag pipe beside the RAM latency; stage 2 steers
// the RAM read data into the video or CPU result registers.
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  rd_tag_t           tag_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              vid_valid_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  output logic [DATA_W-1:0] cpu_rdata_o
);

  rd_tag_t           s1_q;
  rd_tag_t           s2_q;
  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              vid_hit;
  logic              cpu_hit;

  assign vid_hit = s2_q.valid && (s2_q.src == SRC_VID);
  assign cpu_hit = s2_q.valid && (s2_q.src == SRC_CPU);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q        <= '{valid: 1'b0, src: SRC_VID};
      s2_q        <= '{valid: 1'b0, src: SRC_VID};
      vid_valid_q <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      s1_q        <= tag_i;
      s2_q        <= s1_q;
      vid_valid_q <= vid_hit;
      if (vid_hit) vid_rdata_q <= rdata_i;
      if (cpu_hit) cpu_rdata_q <= rdata_i;
    end
  end

  assign vid_valid_o = vid_valid_q;
  assign vid_rdata_o = vid_rdata_q;
  assign cpu_rdata_o = cpu_rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Video-priority arbiter for the single-port VRAM shared with the CPU bus.
// Define VRAM_ARB_STATS_EN to add grant and wait statistics outputs.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int MAX_WAIT = 64
) (
  input  logic              CLK_25MHZ,
  input  logic              RESET,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starved,
`ifdef VRAM_ARB_STATS_EN
  output logic [15:0]       stat_vid_reads,
  output logic [15:0]       stat_cpu_grants,
  output logic [9:0]        stat_max_wait,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [9:0] WAIT_MAX = 10'(MAX_WAIT);

  cpu_state_t        state_q, state_d;
  rd_tag_t           tag_d;
  logic              cpu_busy;
  logic              vid_gnt;
  logic              cpu_gnt;
  logic              cpu_pend;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [9:0]        wait_q, wait_d;
  logic              starved_q, starved_d;

  assign cpu_busy = (state_q != IDLE);
  assign vid_gnt  = vid_req;
  assign cpu_gnt  = !vid_req && cpu_req && !cpu_busy;
  assign cpu_pend = cpu_req && !cpu_busy && !cpu_gnt;

  always_comb begin
    state_d = state_q;
    cpu_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_gnt) state_d = cpu_we ? WR_DONE : RD_WAIT1;
      end
      WR_DONE: begin
        cpu_ack = 1'b1;
        state_d = IDLE;
      end
      RD_WAIT1: state_d = RD_WAIT2;
      RD_WAIT2: state_d = RD_DONE;
      RD_DONE: begin
        cpu_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_d       = '{valid: 1'b0, src: SRC_VID};
    if (vid_gnt) begin
      mem_addr_d = vid_addr;
      tag_d      = '{valid: 1'b1, src: SRC_VID};
    end else if (cpu_gnt) begin
      mem_addr_d = cpu_addr;
      if (cpu_we) mem_wdata_d = cpu_wdata;
      tag_d = '{valid: !cpu_we, src: SRC_CPU};
    end
  end

  // Saturating wait count: the pulse fires only on the step into WAIT_MAX.
  always_comb begin
    wait_d    = wait_q;
    starved_d = 1'b0;
    if (cpu_gnt) begin
      wait_d = '0;
    end else if (cpu_pend && (wait_q != WAIT_MAX)) begin
      wait_d    = wait_q + 10'd1;
      starved_d = (wait_d == WAIT_MAX);
    end
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wait_q      <= '0;
      starved_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= vid_gnt || cpu_gnt;
      mem_we_q    <= cpu_gnt && cpu_we;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wait_q      <= wait_d;
      starved_q   <= starved_d;
    end
  end

  vram_rd_tag_pipe #(
    .DATA_W(DATA_W)
  ) u_tag_pipe (
    .clk_i      (CLK_25MHZ),
    .rst_i      (RESET),
    .tag_i      (tag_d),
    .rdata_i    (mem_rdata),
    .vid_valid_o(vid_valid),
    .vid_rdata_o(vid_rdata),
    .cpu_rdata_o(cpu_rdata)
  );

  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_starved = starved_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] st_vid_q;
  logic [15:0] st_cpu_q;
  logic [9:0]  st_max_q;

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      st_vid_q <= '0;
      st_cpu_q <= '0;
      st_max_q <= '0;
    end else begin
      if (vid_gnt && (st_vid_q != 16'hFFFF)) st_vid_q <= st_vid_q + 16'd1;
      if (cpu_gnt && (st_cpu_q != 16'hFFFF)) st_cpu_q <= st_cpu_q + 16'd1;
      if (wait_q > st_max_q) st_max_q <= wait_q;
    end
  end

  assign stat_vid_reads  = st_vid_q;
  assign stat_cpu_grants = st_cpu_q;
  assign stat_max_wait   = st_max_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter; expected outputs come from a
// cycle-scheduled model of the grant, handshake and starvation rules.
module tb_vram_arbiter;

  localparam int AW   = 13;
  localparam int DW   = 8;
  localparam int MAXW = 64;
  localparam int NW   = 1 << AW;

  logic          clk = 1'b0;
  logic          RESET;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_starved;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #20 clk = ~clk;

  vram_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_WAIT(MAXW)
  ) dut (
    .CLK_25MHZ  (clk),
    .RESET      (RESET),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_valid  (vid_valid),
    .vid_rdata  (vid_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_starved(cpu_starved),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  logic [DW-1:0] ram [0:NW-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    bit            en;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    bit            vv;
    logic [DW-1:0] vd;
    bit            ack;
    bit            rd;
    logic [DW-1:0] crd;
    bit            st;
    bit            zero;
  } exp_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } txn_t;

  exp_t          slot [8];
  txn_t          cpu_q [$];
  logic [DW-1:0] mdl [0:NW-1];
  int            cyc;
  int            free_at;
  int            done_at;
  int            pend;
  int            n_cmp;
  int            n_bad;
  int            n_starve;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input bit v, input logic [AW-1:0] va, input bit rst);
    int   s1;
    int   s3;
    bit   busy;
    bit   gc;
    exp_t e;
    txn_t t;
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_req && (cyc == done_at + 1)) cpu_req = 1'b0;
    if (!cpu_req && (cpu_q.size() > 0)) begin
      t         = cpu_q.pop_front();
      cpu_req   = 1'b1;
      cpu_we    = t.we;
      cpu_addr  = t.addr;
      cpu_wdata = t.wd;
    end
    vid_req  = v;
    vid_addr = va;
    RESET    = rst;
    s1 = (cyc + 1) % 8;
    s3 = (cyc + 3) % 8;
    if (rst) begin
      for (int i = 1; i < 8; i++) slot[(cyc + i) % 8] = '{default: 0};
      slot[s1].zero = 1'b1;
      free_at = 0;
      pend    = 0;
      if (done_at > cyc) done_at = -10;
    end else begin
      busy = (cyc < free_at);
      gc   = !v && cpu_req && !busy;
      if (v) begin
        slot[s1].en   = 1'b1;
        slot[s1].addr = va;
        slot[s3].vv   = 1'b1;
        slot[s3].vd   = mdl[va];
      end
      if (gc) begin
        slot[s1].en   = 1'b1;
        slot[s1].we   = cpu_we;
        slot[s1].addr = cpu_addr;
        pend = 0;
        if (cpu_we) begin
          slot[s1].wd   = cpu_wdata;
          slot[s1].ack  = 1'b1;
          mdl[cpu_addr] = cpu_wdata;
          done_at = cyc + 1;
          free_at = cyc + 2;
        end else begin
          slot[s3].ack = 1'b1;
          slot[s3].rd  = 1'b1;
          slot[s3].crd = mdl[cpu_addr];
          done_at = cyc + 3;
          free_at = cyc + 4;
        end
      end else if (cpu_req && !busy && (pend < MAXW)) begin
        pend++;
        if (pend == MAXW) slot[s1].st = 1'b1;
      end
    end
    @(negedge clk);
    e = slot[cyc % 8];
    slot[cyc % 8] = '{default: 0};
    if (e.zero) begin
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    end
    chk("mem_en", 32'(mem_en), 32'(e.en));
    if (e.en) begin
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
    end
    chk("vid_valid", 32'(vid_valid), 32'(e.vv));
    if (e.vv) chk("vid_rdata", 32'(vid_rdata), 32'(e.vd));
    chk("cpu_ack", 32'(cpu_ack), 32'(e.ack));
    if (e.ack && e.rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.crd));
    chk("cpu_starved", 32'(cpu_starved), 32'(e.st));
    if (cpu_starved === 1'b1) n_starve++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, 1'b0);
  endtask

  initial begin
    int k;
    int pct;
    RESET     = 1'b1;
    vid_req   = 1'b0;
    vid_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cyc       = 0;
    free_at   = 0;
    done_at   = -10;
    pend      = 0;
    n_cmp     = 0;
    n_bad     = 0;
    n_starve  = 0;
    for (int i = 0; i < 8; i++) slot[i] = '{default: 0};
    for (int i = 0; i < NW; i++) begin
      mdl[i] = DW'(i * 37 + 5);
      ram[i] <= DW'(i * 37 + 5);
    end

    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    idle(3);

    cpu_q.push_back('{1'b1, 13'h0123, 8'hA5});
    idle(4);
    cpu_q.push_back('{1'b0, 13'h0123, 8'h00});
    idle(6);

    cpu_q.push_back('{1'b1, 13'h0040, 8'h3C});
    tick(1'b1, 13'h0123, 1'b0);
    idle(5);

    tick(1'b1, 13'h0010, 1'b0);
    cpu_q.push_back('{1'b0, 13'h0040, 8'h00});
    tick(1'b0, '0, 1'b0);
    tick(1'b1, 13'h0010, 1'b0);
    idle(6);

    k = n_starve;
    cpu_q.push_back('{1'b1, 13'h0055, 8'h77});
    repeat (100) tick(1'b1, 13'($urandom_range(0, 63)), 1'b0);
    chk("starve_pulses", 32'(n_starve - k), 32'd1);
    idle(5);

    cpu_q.push_back('{1'b0, 13'h0123, 8'h00});
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1);
    idle(7);

    for (int b = 0; b < 6; b++) begin
      pct = (b % 3 == 0) ? 20 : ((b % 3 == 1) ? 60 : 90);
      for (int i = 0; i < 400; i++) begin
        if ((cpu_q.size() == 0) && ($urandom_range(0, 3) == 0))
          cpu_q.push_back('{bit'($urandom_range(0, 1)),
                            13'($urandom_range(0, 31)),
                            8'($urandom)});
        tick($urandom_range(0, 99) < pct,
             13'($urandom_range(0, 31)),
             $urandom_range(0, 499) == 0);
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the VGA scanout engine and the 8080 CPU bus inside `topEntity`. It runs in the 25 MHz pixel clock domain.
- Video reads have absolute priority, because scanout has a hard deadline.
- CPU reads and writes fill the free cycles, mostly during blanking.
- A pipeline tag routes each read result back to its owner.
- A starvation monitor flags a CPU that has been kept waiting too long.

## Interface
Parameters:
- ADDR_W, 13, VRAM word-address width (7 KiB frame buffer fits).
- DATA_W, 8, data width.
- MAX_WAIT, 64, CPU pending cycles before `cpu_starved` pulses; legal range 1..1023.

Ports:
- CLK_25MHZ  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- vid_req  in  1  video read request, single-cycle, never stalled.
- vid_addr  in  ADDR_W  video read address, valid with `vid_req`.
- vid_valid  out  1  video read data valid pulse.
- vid_rdata  out  DATA_W  video read data.
- cpu_req  in  1  CPU request level; held until `cpu_ack`.
- cpu_we  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- cpu_addr  in  ADDR_W  CPU address; stable while `cpu_req` is high.
- cpu_wdata  in  DATA_W  CPU write data; stable while `cpu_req` is high.
- cpu_ack  out  1  transaction-complete pulse.
- cpu_rdata  out  DATA_W  CPU read data, valid with `cpu_ack` on reads.
- cpu_starved  out  1  one-cycle pulse when the CPU wait count reaches MAX_WAIT.
- mem_en, mem_we  out  1 each  registered RAM command.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data, 1 cycle after `mem_en`.

## Operation
Grant, evaluated in cycle N:
- `vid_req` high: video wins and the CPU is not granted.
- Otherwise the CPU wins if `cpu_req`=1 and `cpu_busy`=0.
- A granted command appears on `mem_*` at N+1.

Read pipeline:
- A 2-stage tag shift register of {valid, src} runs alongside the RAM latency.
- Stage 2 steers the registered `mem_rdata` to the video or CPU outputs.
- A CPU read in flight never blocks video grants, and vice versa.

CPU handshake:
- Acceptance sets `cpu_busy`.
- `cpu_busy` clears the cycle after `cpu_ack`.
- `cpu_req` sampled high after that is a new transaction; the requester updates address and data on `cpu_ack`.

Starvation monitor:
- `wait_cnt` (10 bits) increments each cycle in which `cpu_req` is high, `cpu_busy` is 0 and the CPU is not granted.
- It clears on grant.
- `cpu_starved` pulses once, in the cycle `wait_cnt` reaches MAX_WAIT.
- `wait_cnt` saturates at MAX_WAIT, with no further pulses until a grant.

State machine, CPU side: IDLE -> (grant) WR_DONE or RD_WAIT1 -> RD_WAIT2 -> RD_DONE -> IDLE.

## Timing
| Event | Video read | CPU write | CPU read |
|---|---|---|---|
| Grant in cycle | N | N | N |
| `mem_en` high | N+1 | N+1 | N+1 |
| `mem_rdata` | N+2 | — | N+2 |
| Completion | `vid_valid` + `vid_rdata` at N+3 | `cpu_ack` at N+1 | `cpu_ack` + `cpu_rdata` at N+3 |
| Earliest next CPU accept | — | N+2 | N+4 |

- Video throughput: 1 read per cycle.
- `vid_req` every cycle: the CPU is fully starved. This is legal; only the monitor reacts.
- Reset values: `vid_valid`, `cpu_ack`, `cpu_starved`, `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `vid_rdata`, `cpu_rdata` = 0; `wait_cnt` = 0; state IDLE; tags cleared.
- Reset mid-transaction drops in-flight reads: no `vid_valid` or `cpu_ack` is emitted for them, and the CPU reissues.
- `vid_req` and `cpu_req` in the same cycle: video is granted and the CPU waits. The CPU's first grant is the first cycle with `vid_req`=0.

## Configuration
- `VRAM_ARB_STATS_EN` defined adds three outputs:
  - `stat_vid_reads[15:0]`, saturating count of video grants.
  - `stat_cpu_grants[15:0]`, saturating count of CPU grants.
  - `stat_max_wait[9:0]`, largest `wait_cnt` observed.
  - All three clear on RESET.
- Undefined: these ports and their counters are absent.
- Functional behaviour is identical either way.

## Structure
- Shared package `vram_pkg`:
  - `VRAM_ADDR_W`, `VRAM_DATA_W`.
  - `arb_src_t` enum {SRC_VID, SRC_CPU}.
  - `cpu_state_t` enum {IDLE, WR_DONE, RD_WAIT1, RD_WAIT2, RD_DONE}.
  - `rd_tag_t` struct {valid, src}.
- One natural sub-module, `vram_rd_tag_pipe`: the 2-stage tag and data steering register, parameterised on DATA_W.

## Test plan
- **CPU write:** idle `vid_req`; CPU write addr 0x0123 data 0xA5 -> `mem_en`/`mem_we` at N+1 with addr 0x0123, `cpu_ack` at N+1.
- **CPU readback:** CPU read of 0x0123 -> `cpu_ack` at N+3 with `cpu_rdata`=0xA5; no `vid_valid`.
- **Collision:** `vid_req` and `cpu_req` (write) together at N -> video on `mem_*` at N+1, CPU on `mem_*` at N+2, `cpu_ack` at N+2.
- **Interleaved reads:** video reads 0x0010 at N and N+2, CPU read at N+1 -> data returned to the correct owner at N+3, N+4 and N+5; no cross-routing.
- **Starvation:** `vid_req` held for 100 cycles with `cpu_req` high -> single `cpu_starved` pulse at MAX_WAIT=64 pending cycles; CPU granted in the first cycle `vid_req` drops.
- **Reset mid-read:** RESET asserted one cycle after a CPU read grant -> no `cpu_ack`, all outputs 0 the cycle after RESET; a reissued read completes normally.
